alarm_sequencer: RTL and testbench

Arm/disarm state machine for the alarm system, built around a shared tick timebase: a prescaler divides `clk` into ticks, and a tick counter times the exit delay, entry delay and siren period. It sits between the keypad/sensor front end and the siren/indicator drivers. It is the single owner of the delay timer, so all timed intervals are sequenced from one counter pair and restart cleanly on every state change.

---
 rtl/alarm_sequencer.sv | 116 +++++++++++
 tb/tb_alarm_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// Alarm arm/disarm sequencer with a shared prescaler/tick-counter timebase
// for the exit delay, entry delay and siren period.
module alarm_sequencer #(
    parameter int unsigned TICK_DIV    = 16,
    parameter int unsigned EXIT_TICKS  = 10,
    parameter int unsigned ENTRY_TICKS = 8,
    parameter int unsigned SIREN_TICKS = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arm,
    input  logic       disarm,
    input  logic       door,
    input  logic       motion,
    output logic [2:0] state,
    output logic       armed,
    output logic       siren,
    output logic       beep,
    output logic       alarm_mem
);

    typedef enum logic [2:0] {
        StDisarmed = 3'd0,
        StExit     = 3'd1,
        StArmed    = 3'd2,
        StEntry    = 3'd3,
        StAlarm    = 3'd4
    } state_e;

    localparam logic [7:0] TickLast  = 8'(TICK_DIV - 1);
    localparam logic [7:0] ExitLast  = 8'(EXIT_TICKS - 1);
    localparam logic [7:0] EntryLast = 8'(ENTRY_TICKS - 1);
    localparam logic [7:0] SirenLast = 8'(SIREN_TICKS - 1);

    state_e     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       armed_q, armed_d;
    logic       siren_q, siren_d;
    logic       beep_q, beep_d;
    logic       alarm_mem_q, alarm_mem_d;
    logic       tick;
    logic       changed;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        alarm_mem_d = alarm_mem_q;
        tick        = (presc_q == TickLast);

        case (state_q)
            StDisarmed: if (arm) state_d = StExit;
            StExit:     if (tick && cnt_q == ExitLast) state_d = StArmed;
            StArmed: begin
                if (motion)    state_d = StAlarm;
                else if (door) state_d = StEntry;
            end
            StEntry:    if (tick && cnt_q == EntryLast) state_d = StAlarm;
            StAlarm:    if (tick && cnt_q == SirenLast) state_d = StArmed;
            default:    state_d = StDisarmed;
        endcase
        // Disarm overrides everything, including a same-edge timeout or arm.
        if (disarm) state_d = StDisarmed;

        changed = (state_d != state_q);

        // Every state change restarts the timebase from zero.
        if (changed) begin
            presc_d = 8'd0;
            cnt_d   = 8'd0;
        end else if (tick) begin
            presc_d = 8'd0;
            cnt_d   = cnt_q + 8'd1;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        beep_d = !changed && tick &&
                 ((state_q == StExit  && cnt_q < ExitLast) ||
                  (state_q == StEntry && cnt_q < EntryLast));

        if (state_q == StDisarmed && state_d == StExit) alarm_mem_d = 1'b0;
        if (state_q != StAlarm && state_d == StAlarm)   alarm_mem_d = 1'b1;

        armed_d = (state_d == StArmed) || (state_d == StEntry) || (state_d == StAlarm);
        siren_d = (state_d == StAlarm);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StDisarmed;
            presc_q     <= 8'd0;
            cnt_q       <= 8'd0;
            armed_q     <= 1'b0;
            siren_q     <= 1'b0;
            beep_q      <= 1'b0;
            alarm_mem_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            siren_q     <= siren_d;
            beep_q      <= beep_d;
            alarm_mem_q <= alarm_mem_d;
        end
    end

    assign state     = state_q;
    assign armed     = armed_q;
    assign siren     = siren_q;
    assign beep      = beep_q;
    assign alarm_mem = alarm_mem_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Random-stimulus bench for alarm_sequencer: two parameterisations driven in
// parallel and compared every cycle against a dwell-time reference model.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       arm = 1'b0, disarm = 1'b0, door = 1'b0, motion = 1'b0;
    logic [2:0] state0, state1;
    logic       armed0, armed1, siren0, siren1, beep0, beep1, mem0, mem1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alarm_sequencer #(
        .TICK_DIV(16), .EXIT_TICKS(10), .ENTRY_TICKS(8), .SIREN_TICKS(12)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .disarm(disarm), .door(door),
        .motion(motion), .state(state0), .armed(armed0), .siren(siren0),
        .beep(beep0), .alarm_mem(mem0)
    );

    alarm_sequencer #(
        .TICK_DIV(2), .EXIT_TICKS(1), .ENTRY_TICKS(3), .SIREN_TICKS(2)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .disarm(disarm), .door(door),
        .motion(motion), .state(state1), .armed(armed1), .siren(siren1),
        .beep(beep1), .alarm_mem(mem1)
    );

    // Model: state plus number of edges elapsed since the state was entered.
    typedef struct {
        int   st;
        int   k;
        logic beep;
        logic mem;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.k = 0; r.beep = 1'b0; r.mem = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int td, int ne, int nn, int ns,
                                      logic a, logic d, logic dr, logic mo);
        mdl_t r = m;
        int   k = m.k + 1;
        int   nxt = m.st;
        int   dwell;
        case (m.st)
            0: if (a) nxt = 1;
            1: if (k == ne * td) nxt = 2;
            2: if (mo) nxt = 4; else if (dr) nxt = 3;
            3: if (k == nn * td) nxt = 4;
            4: if (k == ns * td) nxt = 2;
            default: nxt = 0;
        endcase
        if (d) nxt = 0;
        dwell  = (m.st == 1) ? ne * td : nn * td;
        r.beep = (nxt == m.st) && (m.st == 1 || m.st == 3) && (k % td == 0) && (k < dwell);
        if (m.st == 0 && nxt == 1) r.mem = 1'b0;
        if (m.st != 4 && nxt == 4) r.mem = 1'b1;
        r.k  = (nxt != m.st) ? 0 : k;
        r.st = nxt;
        return r;
    endfunction

    function automatic logic [6:0] mdl_pack(mdl_t m);
        logic [2:0] s = 3'(m.st);
        logic       a = (m.st == 2 || m.st == 3 || m.st == 4);
        return {s, a, (m.st == 4), m.beep, m.mem};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic a, input logic d, input logic dr, input logic mo);
        arm = a; disarm = d; door = dr; motion = mo;
        @(posedge clk);
        m0 = mdl_step(m0, 16, 10, 8, 12, a, d, dr, mo);
        m1 = mdl_step(m1, 2, 1, 3, 2, a, d, dr, mo);
        @(negedge clk);
        check("dut0 {state,armed,siren,beep,mem}",
              int'({state0, armed0, siren0, beep0, mem0}), int'(mdl_pack(m0)));
        check("dut1 {state,armed,siren,beep,mem}",
              int'({state1, armed1, siren1, beep1, mem1}), int'(mdl_pack(m1)));
    endtask

    initial begin
        logic dr_l, mo_l;
        dr_l = 1'b0;
        mo_l = 1'b0;
        m0 = mdl_reset();
        m1 = mdl_reset();

        repeat (3) @(negedge clk);
        check("reset dut0", int'({state0, armed0, siren0, beep0, mem0}), 0);
        check("reset dut1", int'({state1, armed1, siren1, beep1, mem1}), 0);
        reset_n = 1'b1;

        // Directed opener: arm, ride through EXIT with arm/motion noise.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 170; i++) cycle(i == 40, 1'b0, 1'b0, i > 60 && i < 100);

        // Random phase: sensor levels wander, arm/disarm are sparse pulses.
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 99) < 2) dr_l = ~dr_l;
            if ($urandom_range(0, 99) < 1) mo_l = ~mo_l;
            cycle($urandom_range(0, 99) < 3, $urandom_range(0, 999) < 4, dr_l, mo_l);
        end

        // Drive dut0 into ALARM, then pull reset between clock edges.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 165; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre-reset siren", int'(siren0), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset state", int'(state0), 0);
        check("async reset armed", int'(armed0), 0);
        check("async reset siren", int'(siren0), 0);
        check("async reset mem", int'(mem0), 0);
        m0 = mdl_reset();
        m1 = mdl_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle(i == 2, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
